// File: rtl/pe_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_pkg
//  Brief    : Shared types, state encodings and output saturation helper
//             for the multi-channel processing element.
//  Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int PE_BITWIDTH  = 16;
    localparam int PE_ACC_WIDTH = 40;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_mac  = 3'd2;
    localparam logic [2:0] c_st_acc  = 3'd3;
    localparam logic [2:0] c_st_out  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = c_st_idle,
        LOAD = c_st_load,
        MAC  = c_st_mac,
        ACC  = c_st_acc,
        OUT  = c_st_out
    } state_t;

    // Clamp a wide signed accumulator into the signed psum range.
    function automatic logic signed [PE_BITWIDTH-1:0] saturate(
        input logic signed [PE_ACC_WIDTH-1:0] acc
    );
        logic signed [PE_ACC_WIDTH-1:0] v_max;
        logic signed [PE_ACC_WIDTH-1:0] v_min;
        v_max = {{(PE_ACC_WIDTH-PE_BITWIDTH+1){1'b0}}, {(PE_BITWIDTH-1){1'b1}}};
        v_min = {{(PE_ACC_WIDTH-PE_BITWIDTH+1){1'b1}}, {(PE_BITWIDTH-1){1'b0}}};
        if (acc > v_max) begin
            saturate = v_max[PE_BITWIDTH-1:0];
        end else if (acc < v_min) begin
            saturate = v_min[PE_BITWIDTH-1:0];
        end else begin
            saturate = acc[PE_BITWIDTH-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_mc_if
//  Brief    : Configuration, operand and psum handshake bundle of pe_mc.
//             master = upstream driver / array fabric, slave = the PE.
//  Revision : 1.0 - initial release
// ============================================================================
interface pe_mc_if #(
    parameter int BITWIDTH      = 16,
    parameter int RF_ADDR_WIDTH = 3,
    parameter int MAX_CHANNELS  = 4
);
    localparam int c_ch_w = $clog2(MAX_CHANNELS) + 1;

    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [RF_ADDR_WIDTH:0]     cfg_filter_size;
    logic [c_ch_w-1:0]          cfg_channels;
    logic                       cfg_use_psum;

    logic                       ifmap_valid;
    logic                       ifmap_ready;
    logic signed [BITWIDTH-1:0] ifmap;

    logic                       filter_valid;
    logic                       filter_ready;
    logic signed [BITWIDTH-1:0] filter;

    logic                       psum_in_valid;
    logic                       psum_in_ready;
    logic signed [BITWIDTH-1:0] psum_in;

    logic                       psum_out_valid;
    logic                       psum_out_ready;
    logic signed [BITWIDTH-1:0] psum_out;

    logic                       busy;

    modport master (
        output cfg_valid, cfg_filter_size, cfg_channels, cfg_use_psum,
        output ifmap_valid, ifmap, filter_valid, filter,
        output psum_in_valid, psum_in, psum_out_ready,
        input  cfg_ready, ifmap_ready, filter_ready, psum_in_ready,
        input  psum_out_valid, psum_out, busy
    );

    modport slave (
        input  cfg_valid, cfg_filter_size, cfg_channels, cfg_use_psum,
        input  ifmap_valid, ifmap, filter_valid, filter,
        input  psum_in_valid, psum_in, psum_out_ready,
        output cfg_ready, ifmap_ready, filter_ready, psum_in_ready,
        output psum_out_valid, psum_out, busy
    );

endinterface
`default_nettype wire

// File: rtl/pe_mc_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : pe_regfile
//  Brief    : Write-pointer register file with asynchronous indexed read.
//             The pointer doubles as the count of words written since the
//             last clear.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_regfile #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata,
    output logic [ADDR_WIDTH:0]   o_count
);
    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]    r_mem [c_depth];
    logic [ADDR_WIDTH:0] r_ptr;

    // Write pointer: cleared on reset or when a new load phase begins.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_we) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Storage: one word per accepted transfer at the current pointer.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_ptr[ADDR_WIDTH-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_count = r_ptr;

endmodule
`default_nettype wire

// File: rtl/pe_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pe_mc
//  Brief    : Multi-channel processing element. Loads K ifmap/filter words
//             per channel, runs K MACs into a wide accumulator over C
//             channels, optionally adds the psum from below, and emits one
//             saturated psum upward.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_mc
    import pe_pkg::*;
#(
    parameter int BITWIDTH      = PE_BITWIDTH,
    parameter int RF_ADDR_WIDTH = 3,
    parameter int RF_DEPTH      = 2 ** RF_ADDR_WIDTH,
    parameter int MAX_CHANNELS  = 4,
    parameter int ACC_WIDTH     = PE_ACC_WIDTH
) (
    input logic    clk,
    input logic    rst,
    pe_mc_if.slave bus
);
    localparam int c_k_w = RF_ADDR_WIDTH + 1;
    localparam int c_c_w = $clog2(MAX_CHANNELS) + 1;
    localparam int c_p_w = 2 * BITWIDTH;
    localparam logic [c_k_w-1:0] c_k_one = c_k_w'(1);
    localparam logic [c_c_w-1:0] c_c_one = c_c_w'(1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_k_w-1:0]           r_k;
    logic [c_c_w-1:0]           r_c;
    logic [c_c_w-1:0]           r_chan;
    logic                       r_p;
    logic [RF_ADDR_WIDTH-1:0]   r_mac_idx;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_nxt;
    logic signed [BITWIDTH-1:0] r_psum_out;
    logic                       r_psum_out_valid;

    logic [c_k_w-1:0]           w_if_cnt;
    logic [c_k_w-1:0]           w_f_cnt;
    logic [BITWIDTH-1:0]        w_if_rd;
    logic [BITWIDTH-1:0]        w_f_rd;
    logic                       w_cfg_fire;
    logic                       w_if_fire;
    logic                       w_f_fire;
    logic                       w_ps_fire;
    logic                       w_out_fire;
    logic                       w_rf_clr;
    logic                       w_if_done;
    logic                       w_f_done;
    logic                       w_mac_last;
    logic                       w_chan_more;
    logic [c_k_w-1:0]           w_k_cfg;
    logic [c_c_w-1:0]           w_c_cfg;
    logic signed [c_p_w-1:0]    w_if_ext;
    logic signed [c_p_w-1:0]    w_f_ext;
    logic signed [c_p_w-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_psum_ext;
    logic signed [BITWIDTH-1:0] w_sat;

    pe_regfile #(.WIDTH(BITWIDTH), .ADDR_WIDTH(RF_ADDR_WIDTH)) u_ifmap_rf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_rf_clr),
        .i_we    (w_if_fire),
        .i_wdata (bus.ifmap),
        .i_raddr (r_mac_idx),
        .o_rdata (w_if_rd),
        .o_count (w_if_cnt)
    );

    pe_regfile #(.WIDTH(BITWIDTH), .ADDR_WIDTH(RF_ADDR_WIDTH)) u_filter_rf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_rf_clr),
        .i_we    (w_f_fire),
        .i_wdata (bus.filter),
        .i_raddr (r_mac_idx),
        .o_rdata (w_f_rd),
        .o_count (w_f_cnt)
    );

    // Readies are pure decodes of state and counters, never of valids.
    assign bus.cfg_ready      = (r_state == IDLE);
    assign bus.ifmap_ready    = (r_state == LOAD) && (w_if_cnt < r_k);
    assign bus.filter_ready   = (r_state == LOAD) && (w_f_cnt < r_k);
    assign bus.psum_in_ready  = (r_state == ACC);
    assign bus.psum_out_valid = r_psum_out_valid;
    assign bus.psum_out       = r_psum_out;
    assign bus.busy           = (r_state != IDLE);

    assign w_cfg_fire = bus.cfg_valid      && bus.cfg_ready;
    assign w_if_fire  = bus.ifmap_valid    && bus.ifmap_ready;
    assign w_f_fire   = bus.filter_valid   && bus.filter_ready;
    assign w_ps_fire  = bus.psum_in_valid  && bus.psum_in_ready;
    assign w_out_fire = r_psum_out_valid   && bus.psum_out_ready;

    // Out-of-range K and C fold to the nearest legal value.
    assign w_k_cfg = (bus.cfg_filter_size == '0)                 ? c_k_one :
                     (bus.cfg_filter_size > c_k_w'(RF_DEPTH))    ? c_k_w'(RF_DEPTH) :
                     bus.cfg_filter_size;
    assign w_c_cfg = (bus.cfg_channels == '0)                    ? c_c_one :
                     (bus.cfg_channels > c_c_w'(MAX_CHANNELS))   ? c_c_w'(MAX_CHANNELS) :
                     bus.cfg_channels;

    // Load completes when both counts reach K, including this edge's transfer.
    assign w_if_done   = (w_if_cnt + c_k_w'(w_if_fire)) == r_k;
    assign w_f_done    = (w_f_cnt  + c_k_w'(w_f_fire))  == r_k;
    assign w_mac_last  = ({1'b0, r_mac_idx} + c_k_one) == r_k;
    assign w_chan_more = (r_chan + c_c_one) < r_c;

    // Full-precision product and sign extension into the accumulator width.
    assign w_if_ext   = {{BITWIDTH{w_if_rd[BITWIDTH-1]}}, w_if_rd};
    assign w_f_ext    = {{BITWIDTH{w_f_rd[BITWIDTH-1]}}, w_f_rd};
    assign w_prod     = w_if_ext * w_f_ext;
    assign w_prod_ext = {{(ACC_WIDTH-c_p_w){w_prod[c_p_w-1]}}, w_prod};
    assign w_psum_ext = {{(ACC_WIDTH-BITWIDTH){bus.psum_in[BITWIDTH-1]}}, bus.psum_in};

    // Saturation only ever applies to the value leaving the PE.
    generate
        if (BITWIDTH == PE_BITWIDTH && ACC_WIDTH == PE_ACC_WIDTH) begin : g_sat_pkg
            assign w_sat = saturate(w_acc_nxt);
        end else begin : g_sat_gen
            localparam logic signed [ACC_WIDTH-1:0] c_max =
                {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] c_min =
                {{(ACC_WIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
            assign w_sat = (w_acc_nxt > c_max) ? c_max[BITWIDTH-1:0] :
                           (w_acc_nxt < c_min) ? c_min[BITWIDTH-1:0] :
                           w_acc_nxt[BITWIDTH-1:0];
        end
    endgenerate

    // Next-state, accumulator update and register-file clear decode.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rf_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cfg_fire) begin
                    w_state_nxt = LOAD;
                    w_acc_nxt   = '0;
                    w_rf_clr    = 1'b1;
                end
            end
            LOAD: begin
                if (w_if_done && w_f_done) begin
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                w_acc_nxt = r_acc + w_prod_ext;
                if (w_mac_last) begin
                    if (w_chan_more) begin
                        w_state_nxt = LOAD;
                        w_rf_clr    = 1'b1;
                    end else if (r_p) begin
                        w_state_nxt = ACC;
                    end else begin
                        w_state_nxt = OUT;
                    end
                end
            end
            ACC: begin
                if (w_ps_fire) begin
                    w_acc_nxt   = r_acc + w_psum_ext;
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (w_out_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job configuration, MAC indexing, accumulator and registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k              <= '0;
            r_c              <= '0;
            r_p              <= 1'b0;
            r_chan           <= '0;
            r_mac_idx        <= '0;
            r_acc            <= '0;
            r_psum_out       <= '0;
            r_psum_out_valid <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            if (w_cfg_fire) begin
                r_k       <= w_k_cfg;
                r_c       <= w_c_cfg;
                r_p       <= bus.cfg_use_psum;
                r_chan    <= '0;
                r_mac_idx <= '0;
            end
            if (r_state == MAC) begin
                if (w_mac_last) begin
                    r_mac_idx <= '0;
                    if (w_chan_more) begin
                        r_chan <= r_chan + c_c_one;
                    end
                end else begin
                    r_mac_idx <= r_mac_idx + RF_ADDR_WIDTH'(1);
                end
            end
            if (w_state_nxt == OUT && r_state != OUT) begin
                r_psum_out       <= w_sat;
                r_psum_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_psum_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_mc
//  Brief    : Self-checking bench for pe_mc against a dot-product model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pe_mc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_mc_if #(.BITWIDTH(16), .RF_ADDR_WIDTH(3), .MAX_CHANNELS(4)) bus ();

    pe_mc #(
        .BITWIDTH(16), .RF_ADDR_WIDTH(3), .RF_DEPTH(8), .MAX_CHANNELS(4), .ACC_WIDTH(40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] ifm_q [0:31];
    logic signed [15:0] flt_q [0:31];
    logic signed [15:0] psum_val;

    logic signed [15:0] obs_res;
    int                 obs_lat, obs_if, obs_f, obs_ps;
    bit                 obs_stable, obs_timeout, obs_idle_after;
    logic [1:0]         obs_pre_abort;

    function automatic int k_eff(input int k);
        return (k == 0) ? 1 : ((k > 8) ? 8 : k);
    endfunction

    function automatic int c_eff(input int c);
        return (c == 0) ? 1 : ((c > 4) ? 4 : c);
    endfunction

    // Reference: one long dot product over all channels, plus psum, clamped.
    function automatic logic signed [15:0] model(input int k, input int c, input bit p);
        longint s = 0;
        for (int j = 0; j < k_eff(k) * c_eff(c); j++) begin
            s += longint'(ifm_q[j]) * longint'(flt_q[j]);
        end
        if (p) s += longint'(psum_val);
        if (s > 32767) return 16'sh7fff;
        if (s < -32768) return 16'sh8000;
        return s[15:0];
    endfunction

    task automatic fill_data(input int n, input bit full_range);
        for (int j = 0; j < n; j++) begin
            ifm_q[j] = full_range ? 16'($urandom) : 16'($urandom_range(40)) - 16'd20;
            flt_q[j] = full_range ? 16'($urandom) : 16'($urandom_range(40)) - 16'd20;
        end
        psum_val = full_range ? 16'($urandom) : 16'($urandom_range(200)) - 16'd100;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid      = 1'b0;
        bus.ifmap_valid    = 1'b0;
        bus.filter_valid   = 1'b0;
        bus.psum_in_valid  = 1'b0;
        bus.psum_out_ready = 1'b0;
    endtask

    // Drives one job with optional valid gaps and output stall; records what
    // the DUT did. Streams keep valid high with junk once their data is spent.
    task automatic run_job(input int k, input int c, input bit p,
                           input int gap, input int stall, input int rst_at);
        int n, if_idx, f_idx, cyc, stall_left;
        bit cfg_done, if_pend, f_pend, ps_pend, ps_sent, done, seen, aborted;
        logic signed [15:0] first_val;
        n = k_eff(k) * c_eff(c);
        if_idx = 0; f_idx = 0; cyc = -1; stall_left = stall;
        cfg_done = 0; if_pend = 0; f_pend = 0; ps_pend = 0; ps_sent = 0;
        done = 0; seen = 0; aborted = 0; first_val = '0;
        obs_res = 'x; obs_lat = -1; obs_if = 0; obs_f = 0; obs_ps = 0;
        obs_stable = 1; obs_timeout = 0; obs_idle_after = 0; obs_pre_abort = '0;
        bus.cfg_filter_size = 4'(k);
        bus.cfg_channels    = 3'(c);
        bus.cfg_use_psum    = p;
        @(negedge clk);
        for (int t = 0; t < 4000 && !done && !aborted; t++) begin
            if (cyc >= 0 && bus.psum_out_valid) begin
                if (!seen) begin
                    seen = 1; first_val = bus.psum_out; obs_lat = cyc;
                end else if (bus.psum_out !== first_val) begin
                    obs_stable = 0;
                end
            end else if (seen) begin
                obs_stable = 0;
            end
            if (rst_at >= 0 && cyc == rst_at) begin
                obs_pre_abort = {bus.busy, bus.ifmap_ready};
                aborted = 1;
                rst = 1'b1;
                idle_inputs();
            end else begin
                bus.cfg_valid = !cfg_done;
                if (!if_pend) begin
                    bus.ifmap_valid = ($urandom_range(99) >= 32'(gap));
                    bus.ifmap = (if_idx < n) ? ifm_q[if_idx] : 16'($urandom);
                end
                if (!f_pend) begin
                    bus.filter_valid = ($urandom_range(99) >= 32'(gap));
                    bus.filter = (f_idx < n) ? flt_q[f_idx] : 16'($urandom);
                end
                if (!ps_pend) begin
                    bus.psum_in_valid = ($urandom_range(99) >= 32'(gap));
                    bus.psum_in = ps_sent ? 16'($urandom) : psum_val;
                end
                if (bus.psum_out_valid && stall_left > 0) begin
                    bus.psum_out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.psum_out_ready = bus.psum_out_valid;
                end
                if (bus.cfg_valid && bus.cfg_ready) begin
                    cfg_done = 1; cyc = 0;
                end
                if (bus.ifmap_valid && bus.ifmap_ready) begin
                    obs_if++; if_idx++; if_pend = 0;
                end else if_pend = bus.ifmap_valid;
                if (bus.filter_valid && bus.filter_ready) begin
                    obs_f++; f_idx++; f_pend = 0;
                end else f_pend = bus.filter_valid;
                if (bus.psum_in_valid && bus.psum_in_ready) begin
                    obs_ps++; ps_sent = 1; ps_pend = 0;
                end else ps_pend = bus.psum_in_valid;
                if (bus.psum_out_valid && bus.psum_out_ready) begin
                    done = 1; obs_res = bus.psum_out;
                end
                @(negedge clk);
                if (cyc >= 0) cyc++;
            end
        end
        if (!aborted) begin
            obs_timeout    = !done;
            obs_idle_after = (bus.psum_out_valid === 1'b0) && (bus.cfg_ready === 1'b1);
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.cfg_ready, bus.ifmap_ready, bus.filter_ready, bus.psum_in_ready,
             bus.busy, bus.psum_out_valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {bus.cfg_ready, bus.ifmap_ready, bus.filter_ready,
                      bus.psum_in_ready, bus.busy, bus.psum_out_valid});
        end
        n_checks++;
        if (bus.psum_out !== 16'sd0) begin
            n_fail++; $display("FAIL reset_psum_out: got %0d expected 0", bus.psum_out);
        end
    endtask

    task automatic test_basic();
        ifm_q[0] = 1; ifm_q[1] = 2; ifm_q[2] = 3;
        flt_q[0] = 4; flt_q[1] = 5; flt_q[2] = 6;
        psum_val = 16'sd1000;
        run_job(3, 1, 0, 0, 0, -1);
        n_checks++;
        if (obs_timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout expected completion"); end
        n_checks++;
        if (obs_res !== 16'sd32) begin n_fail++; $display("FAIL basic_result: got %0d expected 32", obs_res); end
        n_checks++;
        if (obs_lat != 7) begin n_fail++; $display("FAIL basic_latency: got %0d expected 7", obs_lat); end
        n_checks++;
        if (obs_if != 3 || obs_f != 3 || obs_ps != 0) begin
            n_fail++; $display("FAIL basic_transfers: got %0d/%0d/%0d expected 3/3/0", obs_if, obs_f, obs_ps);
        end
        n_checks++;
        if (!obs_idle_after) begin n_fail++; $display("FAIL basic_idle_after: got not idle expected idle"); end
    endtask

    task automatic test_multichannel();
        ifm_q[0] = 1; ifm_q[1] = 1; ifm_q[2] = 3; ifm_q[3] = 0;
        flt_q[0] = 2; flt_q[1] = 2; flt_q[2] = 1; flt_q[3] = 9;
        psum_val = -16'sd10;
        run_job(2, 2, 1, 0, 0, -1);
        n_checks++;
        if (obs_res !== -16'sd3) begin n_fail++; $display("FAIL multi_result: got %0d expected -3", obs_res); end
        n_checks++;
        if (obs_lat != 10) begin n_fail++; $display("FAIL multi_latency: got %0d expected 10", obs_lat); end
        n_checks++;
        if (obs_ps != 1 || obs_timeout) begin
            n_fail++; $display("FAIL multi_psum_transfers: got %0d timeout=%0d expected 1 timeout=0", obs_ps, obs_timeout);
        end
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 8; j++) begin ifm_q[j] = 16'sh7fff; flt_q[j] = 16'sh7fff; end
        psum_val = 0;
        run_job(8, 1, 0, 0, 0, -1);
        n_checks++;
        if (obs_res !== 16'sh7fff) begin n_fail++; $display("FAIL sat_pos: got %0d expected 32767", obs_res); end
        for (int j = 0; j < 8; j++) flt_q[j] = 16'sh8000;
        run_job(8, 1, 0, 0, 0, -1);
        n_checks++;
        if (obs_res !== 16'sh8000) begin n_fail++; $display("FAIL sat_neg: got %0d expected -32768", obs_res); end
    endtask

    task automatic test_back_to_back_stress();
        logic signed [15:0] exp;
        for (int r = 0; r < 3; r++) begin
            fill_data(15, r[0]);
            exp = model(5, 3, 1);
            run_job(5, 3, 1, 40, 5, -1);
            n_checks++;
            if (obs_res !== exp || obs_timeout) begin
                n_fail++; $display("FAIL stress_result[%0d]: got %0d expected %0d", r, obs_res, exp);
            end
            n_checks++;
            if (!obs_stable) begin n_fail++; $display("FAIL stress_stable[%0d]: got unstable expected stable", r); end
            n_checks++;
            if (obs_if != 15 || obs_f != 15 || obs_ps != 1) begin
                n_fail++; $display("FAIL stress_transfers[%0d]: got %0d/%0d/%0d expected 15/15/1", r, obs_if, obs_f, obs_ps);
            end
        end
    endtask

    task automatic test_cfg_edges();
        int ks [4] = '{0, 12, 4, 3};
        int cs [4] = '{2, 1, 0, 7};
        bit ps [4] = '{1, 0, 1, 0};
        logic signed [15:0] exp;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = k_eff(ks[i]) * c_eff(cs[i]);
            fill_data(n, 1'b0);
            exp = model(ks[i], cs[i], ps[i]);
            run_job(ks[i], cs[i], ps[i], 10, 1, -1);
            n_checks++;
            if (obs_res !== exp || obs_timeout) begin
                n_fail++; $display("FAIL cfg_edge_result[K=%0d C=%0d]: got %0d expected %0d", ks[i], cs[i], obs_res, exp);
            end
            n_checks++;
            if (obs_if != n || obs_f != n) begin
                n_fail++; $display("FAIL cfg_edge_transfers[K=%0d C=%0d]: got %0d/%0d expected %0d", ks[i], cs[i], obs_if, obs_f, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] exp;
        fill_data(4, 1'b0);
        run_job(2, 2, 1, 0, 0, 7);
        n_checks++;
        if (obs_pre_abort !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_in_mac: got busy/ifmap_ready %b expected 10", obs_pre_abort);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.psum_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: got cfg_ready=%b busy=%b valid=%b expected 1 0 0",
                               bus.cfg_ready, bus.busy, bus.psum_out_valid);
        end
        n_checks++;
        if (bus.psum_out !== 16'sd0) begin n_fail++; $display("FAIL rstmid_psum_out: got %0d expected 0", bus.psum_out); end
        fill_data(6, 1'b0);
        exp = model(3, 2, 1);
        run_job(3, 2, 1, 20, 2, -1);
        n_checks++;
        if (obs_res !== exp || obs_timeout) begin
            n_fail++; $display("FAIL rstmid_fresh_job: got %0d expected %0d", obs_res, exp);
        end
    endtask

    task automatic test_random();
        int k, c, gap, stall, n;
        bit p;
        logic signed [15:0] exp;
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(15); c = $urandom_range(7); p = 1'($urandom);
            gap = $urandom_range(50); stall = $urandom_range(3);
            n = k_eff(k) * c_eff(c);
            fill_data(n, 1'($urandom));
            exp = model(k, c, p);
            run_job(k, c, p, gap, stall, -1);
            n_checks++;
            if (obs_res !== exp || obs_timeout) begin
                n_fail++; $display("FAIL random_result[%0d K=%0d C=%0d P=%0d]: got %0d expected %0d", r, k, c, p, obs_res, exp);
            end
            n_checks++;
            if (obs_if != n || obs_f != n || obs_ps != int'(p)) begin
                n_fail++; $display("FAIL random_transfers[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", r, obs_if, obs_f, obs_ps, n, n, p);
            end
            n_checks++;
            if (!obs_stable || !obs_idle_after) begin
                n_fail++; $display("FAIL random_output_hold[%0d]: got stable=%0d idle=%0d expected 1 1", r, obs_stable, obs_idle_after);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_filter_size = '0; bus.cfg_channels = '0; bus.cfg_use_psum = 1'b0;
        bus.ifmap = '0; bus.filter = '0; bus.psum_in = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_multichannel();
        test_saturation();
        test_back_to_back_stress();
        test_cfg_edges();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
